layer_0_input_feeder: RTL and testbench
=======================================

# layer_0_input_feeder

Streams one input image per run from the image RAM into the layer-0 convolution array. It sits directly downstream of the network manager: it starts an image whenever `layer_0_en` is high, reads the image selected by `image_idx` in row-major order, and flags the pixels at which a full KERNEL_SIZE×KERNEL_SIZE window is available. It pulses `layer_0_calc_fin` once per completed image, which the manager uses to advance the image index and, after the last image, drop the enable.

## Interface
- IMAGE_SIZE, 4 — image width = height in pixels; ≥ KERNEL_SIZE.
- KERNEL_SIZE, 3 — convolution window edge; ≥ 1.
- DATA_WIDTH, 32 — pixel word width.
- ADDR_WIDTH, 8 — RAM address width; must hold IMAGE_NUM·IMAGE_SIZE² − 1.
- IDX_WIDTH, 4 — image index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- layer_0_en  in  1  level enable from the network manager.
- image_idx  in  IDX_WIDTH  image to load; sampled on the IDLE→READ transition.
- ram_rd_en  out  1  RAM read strobe.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_rdata  in  DATA_WIDTH  RAM data; valid exactly 1 cycle after `ram_rd_en`.
- pixel_out  out  DATA_WIDTH  registered pixel to the convolution array.
- pixel_valid  out  1  `pixel_out` valid this cycle.
- window_valid  out  1  qualifies `pixel_valid`; a full window ends at this pixel.
- layer_0_calc_fin  out  1  one-cycle pulse; image complete.

## Operation
- The FSM has four states: IDLE, READ, DRAIN and DONE. The reset state is IDLE.
- IDLE: when `layer_0_en` is 1, go to READ on the next edge. On the same edge, latch base = image_idx·IMAGE_SIZE², truncated to ADDR_WIDTH, and clear rd_cnt.
- READ: `ram_rd_en`=1 and `ram_addr`=base+rd_cnt, with rd_cnt incrementing 0…IMAGE_SIZE²−1. After issuing the last address, go to DRAIN.
- DRAIN: lasts exactly 2 cycles, so the last read can return and be registered. There are no reads. Then go to DONE.
- DONE: lasts 1 cycle, with `layer_0_calc_fin`=1. Then go to IDLE unconditionally.
- Back in IDLE, if `layer_0_en` is still high, the block starts the next image using the manager's updated `image_idx`. After the last image the manager has dropped the enable, so the block stays in IDLE.
- Data path: rd_en_d1 <= ram_rd_en. When rd_en_d1 is high, `pixel_out` <= `ram_rdata`. `pixel_valid` <= rd_en_d1.
- Output-side counters row and col are both 0…IMAGE_SIZE−1.
  - They advance on each `pixel_valid`: col wraps to 0 and increments row.
  - Both reset to 0 on entering READ.
- window_valid = pixel_valid && row ≥ KERNEL_SIZE−1 && col ≥ KERNEL_SIZE−1. It is registered together with `pixel_out`.
- Windows per image = (IMAGE_SIZE−KERNEL_SIZE+1)².
- Abort: if `layer_0_en` falls while in READ or DRAIN, the block behaves as follows:
  - It returns to IDLE on the next edge with no `calc_fin`.
  - It deasserts `ram_rd_en` immediately (combinational on state).
  - It clears rd_en_d1, `pixel_valid` and `window_valid` on that edge.
- `layer_0_en` is ignored in DONE.
- Reset, asynchronous and at any time: state=IDLE and all counters 0. Every output is 0: `ram_rd_en`, `ram_addr`, `pixel_out`, `pixel_valid`, `window_valid`, `layer_0_calc_fin`.

## Timing
- Let cycle S be the first READ cycle. `layer_0_en` is sampled high in IDLE at cycle S−1.
- Read of pixel k issues at cycle S+k. `pixel_out` and `pixel_valid` for pixel k appear at cycle S+k+2.
- The last pixel is at S+IMAGE_SIZE²+1. DRAIN covers S+N² to S+N²+1, where N=IMAGE_SIZE.
- DONE and `calc_fin` occur at S+N²+2, one cycle after the last `pixel_valid`.
- Back-to-back images: IDLE at S+N²+3, next READ at S+N²+4. The image-to-image period is N²+4 cycles.
- `ram_addr` holds its last value when `ram_rd_en`=0.
- `pixel_out` holds between valids.

## Test plan
- Reset, then `layer_0_en`=1 with idx=0 (N=4, K=3): addresses 0…15 over 16 consecutive cycles, then 16 `pixel_valid`s. `window_valid` is high on exactly pixels 10, 11, 14 and 15. `calc_fin` is a single pulse at S+18.
- Continuous enable, with the manager model incrementing idx on `calc_fin`: the second image reads addresses 16…31, starting 20 cycles after the first image's S.
- Model with IMAGE_NUM=2 that drops the enable after `calc_fin`: exactly two `calc_fin` pulses, then the block stays in IDLE with `ram_rd_en`=0.
- Drop `layer_0_en` at READ cycle S+5: `ram_rd_en` is 0 in the same cycle, no `calc_fin` follows, and `pixel_valid` is 0 from S+6. Re-enabling restarts at base address 0.
- Assert `rst_n` low at cycle S+8: all outputs go to 0 immediately. After release with the enable high, a full image completes correctly.
- N=3, K=3, idx=2: addresses 18…26, exactly one `window_valid` (pixel 8), and `calc_fin` at S+11.

Source files
------------

// File: rtl/layer_0_input_feeder_if.sv
// Signal bundle between the layer-0 input feeder and its surroundings:
// manager control, image RAM read port and the pixel stream to the conv array.
interface layer_0_input_feeder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int IDX_WIDTH  = 4
);
   logic                  layer_0_en;
   logic [IDX_WIDTH-1:0]  image_idx;
   logic                  ram_rd_en;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [DATA_WIDTH-1:0] pixel_out;
   logic                  pixel_valid;
   logic                  window_valid;
   logic                  layer_0_calc_fin;

   // The feeder is the master: it owns the RAM request and the pixel stream.
   modport master (
      input  layer_0_en,
      input  image_idx,
      input  ram_rdata,
      output ram_rd_en,
      output ram_addr,
      output pixel_out,
      output pixel_valid,
      output window_valid,
      output layer_0_calc_fin
   );

   modport slave (
      output layer_0_en,
      output image_idx,
      output ram_rdata,
      input  ram_rd_en,
      input  ram_addr,
      input  pixel_out,
      input  pixel_valid,
      input  window_valid,
      input  layer_0_calc_fin
   );
endinterface

// File: rtl/layer_0_input_feeder.sv
// Streams one image per run from the image RAM to the layer-0 convolution
// array in row-major order, flagging pixels where a full kernel window ends.
module layer_0_input_feeder #(
   parameter int IMAGE_SIZE  = 4,
   parameter int KERNEL_SIZE = 3,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   layer_0_input_feeder_if.master bus
);
   localparam int PIXELS    = IMAGE_SIZE * IMAGE_SIZE;
   localparam int POS_WIDTH = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

   localparam logic [ADDR_WIDTH-1:0] LAST_CNT  = ADDR_WIDTH'(PIXELS - 1);
   localparam logic [ADDR_WIDTH-1:0] PIX_PER   = ADDR_WIDTH'(PIXELS);
   localparam logic [POS_WIDTH-1:0]  LAST_POS  = POS_WIDTH'(IMAGE_SIZE - 1);
   localparam logic [POS_WIDTH-1:0]  WIN_START = POS_WIDTH'(KERNEL_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] rd_cnt_q;
   logic                  drain_cnt_q;
   logic                  calc_fin_q;

   logic                  rd_en_d1_q;
   logic [DATA_WIDTH-1:0] pixel_q;
   logic                  pixel_valid_q;
   logic                  window_valid_q;
   logic [POS_WIDTH-1:0]  row_q;
   logic [POS_WIDTH-1:0]  col_q;

   logic                  en;
   logic [IDX_WIDTH-1:0]  idx;
   logic [ADDR_WIDTH-1:0] base_d;
   logic                  start;
   logic                  abort;
   logic                  rd_en;

   assign en  = bus.layer_0_en;
   assign idx = bus.image_idx;

   // Multiplying in ADDR_WIDTH arithmetic gives the truncated base directly.
   assign base_d = ADDR_WIDTH'(idx) * PIX_PER;

   assign start = (state_q == IDLE) && en;
   assign abort = ((state_q == READ) || (state_q == DRAIN)) && !en;
   assign rd_en = (state_q == READ) && en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         rd_cnt_q    <= '0;
         drain_cnt_q <= 1'b0;
         calc_fin_q  <= 1'b0;
      end else begin
         calc_fin_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en) begin
                  state_q  <= READ;
                  base_q   <= base_d;
                  rd_cnt_q <= '0;
               end
            end
            READ: begin
               if (!en) begin
                  state_q <= IDLE;
               end else if (rd_cnt_q == LAST_CNT) begin
                  // rd_cnt holds on the last address so ram_addr stays put.
                  state_q     <= DRAIN;
                  drain_cnt_q <= 1'b0;
               end else begin
                  rd_cnt_q <= rd_cnt_q + 1'b1;
               end
            end
            DRAIN: begin
               if (!en) begin
                  state_q <= IDLE;
               end else if (drain_cnt_q) begin
                  state_q    <= DONE;
                  calc_fin_q <= 1'b1;
               end else begin
                  drain_cnt_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Returned data path: row/col index the pixel being registered this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_d1_q     <= 1'b0;
         pixel_q        <= '0;
         pixel_valid_q  <= 1'b0;
         window_valid_q <= 1'b0;
         row_q          <= '0;
         col_q          <= '0;
      end else if (abort) begin
         rd_en_d1_q     <= 1'b0;
         pixel_valid_q  <= 1'b0;
         window_valid_q <= 1'b0;
      end else begin
         rd_en_d1_q     <= rd_en;
         pixel_valid_q  <= rd_en_d1_q;
         window_valid_q <= rd_en_d1_q && (row_q >= WIN_START) && (col_q >= WIN_START);
         if (rd_en_d1_q) begin
            pixel_q <= bus.ram_rdata;
         end
         if (start) begin
            row_q <= '0;
            col_q <= '0;
         end else if (rd_en_d1_q) begin
            if (col_q == LAST_POS) begin
               col_q <= '0;
               row_q <= (row_q == LAST_POS) ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
      end
   end

   assign bus.ram_rd_en        = rd_en;
   assign bus.ram_addr         = base_q + rd_cnt_q;
   assign bus.pixel_out        = pixel_q;
   assign bus.pixel_valid      = pixel_valid_q;
   assign bus.window_valid     = window_valid_q;
   assign bus.layer_0_calc_fin = calc_fin_q;
endmodule

// File: tb/tb_layer_0_input_feeder.sv
// Bench for layer_0_input_feeder: two instances (4x4 and 3x3 images, 3x3 kernel)
// checked every cycle against a timing-based reference plus directed literals.
module tb_layer_0_input_feeder;
   localparam int K = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  en;
   logic [3:0]  idx     [2];
   logic [31:0] rdata_q [2];
   logic [1:0]  rd_w, pv_w, wv_w, fin_w;
   logic [7:0]  addr_w  [2];
   logic [31:0] pout_w  [2];

   layer_0_input_feeder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .IDX_WIDTH(4)) bus0 ();
   layer_0_input_feeder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .IDX_WIDTH(4)) bus1 ();

   layer_0_input_feeder #(.IMAGE_SIZE(4), .KERNEL_SIZE(3), .DATA_WIDTH(32), .ADDR_WIDTH(8), .IDX_WIDTH(4))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   layer_0_input_feeder #(.IMAGE_SIZE(3), .KERNEL_SIZE(3), .DATA_WIDTH(32), .ADDR_WIDTH(8), .IDX_WIDTH(4))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   assign bus0.layer_0_en = en[0];
   assign bus0.image_idx  = idx[0];
   assign bus0.ram_rdata  = rdata_q[0];
   assign bus1.layer_0_en = en[1];
   assign bus1.image_idx  = idx[1];
   assign bus1.ram_rdata  = rdata_q[1];

   assign rd_w[0]   = bus0.ram_rd_en;
   assign rd_w[1]   = bus1.ram_rd_en;
   assign addr_w[0] = bus0.ram_addr;
   assign addr_w[1] = bus1.ram_addr;
   assign pout_w[0] = bus0.pixel_out;
   assign pout_w[1] = bus1.pixel_out;
   assign pv_w[0]   = bus0.pixel_valid;
   assign pv_w[1]   = bus1.pixel_valid;
   assign wv_w[0]   = bus0.window_valid;
   assign wv_w[1]   = bus1.window_valid;
   assign fin_w[0]  = bus0.layer_0_calc_fin;
   assign fin_w[1]  = bus1.layer_0_calc_fin;

   // RAM contents are a fixed function of the address.
   function automatic logic [31:0] pix(input logic [7:0] a);
      return {8'hA5, a, ~a, 8'h3C};
   endfunction

   function automatic int nsz(input int i);
      return (i == 0) ? 4 : 3;
   endfunction

   always @(posedge clk) begin
      if (rd_w[0]) rdata_q[0] <= pix(addr_w[0]);
      if (rd_w[1]) rdata_q[1] <= pix(addr_w[1]);
   end

   // Reference: a run is described only by its start cycle S and base address;
   // every output is a function of the phase (cycle - S).
   int          cyc = 0;
   bit          m_act  [2] = '{1'b0, 1'b0};
   int          m_s    [2] = '{0, 0};
   logic [7:0]  m_base [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int n2;
         n2 = nsz(i) * nsz(i);
         if (!rst_n) begin
            m_act[i] = 1'b0;
         end else if (m_act[i]) begin
            if (cyc - m_s[i] == n2 + 2) m_act[i] = 1'b0;
            else if (!en[i])            m_act[i] = 1'b0;
         end else if (en[i]) begin
            m_act[i]  = 1'b1;
            m_s[i]    = cyc + 1;
            m_base[i] = 8'(int'(idx[i]) * n2);
         end
      end
      cyc = cyc + 1;
   end

   int checks   = 0;
   int failures = 0;

   int          run_start [2] = '{0, 0};
   int          fin_cyc   [2] = '{0, 0};
   int          fin_total [2] = '{0, 0};
   int          pix_cnt   [2] = '{0, 0};
   logic [15:0] wmask     [2];
   logic [7:0]  run_addr0 [2];
   logic [7:0]  last_addr [2];
   logic [31:0] first_pix [2];
   logic [1:0]  rd_prev = 2'b00;

   task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d got=%0h expected=%0h cycle=%0d", nm, i, act, exp, cyc);
      end
   endtask

   task automatic compare_cycle();
      for (int i = 0; i < 2; i++) begin
         int ph, n, k;
         logic e_rd, e_pv, e_wv, e_fin;
         logic [31:0] e_pix;
         n = nsz(i);
         e_rd = 1'b0; e_pv = 1'b0; e_wv = 1'b0; e_fin = 1'b0; e_pix = '0; k = 0;
         if (rst_n && m_act[i]) begin
            ph    = cyc - m_s[i];
            e_rd  = (ph < n * n) && en[i];
            e_fin = (ph == n * n + 2);
            if (ph >= 2 && ph < n * n + 2) begin
               k     = ph - 2;
               e_pv  = 1'b1;
               e_wv  = (k / n >= K - 1) && (k % n >= K - 1);
               e_pix = pix(8'(int'(m_base[i]) + k));
            end
         end
         chk("rd_en", i, 64'(rd_w[i]), 64'(e_rd));
         if (e_rd) chk("addr", i, 64'(addr_w[i]), 64'(m_base[i] + 8'(cyc - m_s[i])));
         chk("pixel_valid", i, 64'(pv_w[i]), 64'(e_pv));
         chk("window_valid", i, 64'(wv_w[i]), 64'(e_wv));
         if (e_pv) chk("pixel_out", i, 64'(pout_w[i]), 64'(e_pix));
         chk("calc_fin", i, 64'(fin_w[i]), 64'(e_fin));
         // Observation log used by the directed literal checks.
         if (rd_w[i] && !rd_prev[i]) begin
            run_start[i] = cyc; run_addr0[i] = addr_w[i]; pix_cnt[i] = 0; wmask[i] = '0;
         end
         if (rd_w[i]) last_addr[i] = addr_w[i];
         if (pv_w[i]) begin
            if (pix_cnt[i] == 0) first_pix[i] = pout_w[i];
            if (wv_w[i]) wmask[i][pix_cnt[i]] = 1'b1;
            pix_cnt[i]++;
         end
         if (fin_w[i]) begin
            fin_cyc[i] = cyc; fin_total[i]++;
         end
         rd_prev[i] = rd_w[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fin(input int i, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fin_w[i] && n < budget);
      #1;
      chk("fin_seen", i, 64'(fin_w[i]), 64'd1);
   endtask

   task automatic chk_zero(input int i, input string nm);
      chk({nm, "_rd_en"}, i, 64'(rd_w[i]), 64'd0);
      chk({nm, "_addr"}, i, 64'(addr_w[i]), 64'd0);
      chk({nm, "_pixel_out"}, i, 64'(pout_w[i]), 64'd0);
      chk({nm, "_pixel_valid"}, i, 64'(pv_w[i]), 64'd0);
      chk({nm, "_window_valid"}, i, 64'(wv_w[i]), 64'd0);
      chk({nm, "_calc_fin"}, i, 64'(fin_w[i]), 64'd0);
   endtask

   initial begin
      int s, f0;
      rst_n = 1'b0; en = 2'b00; idx[0] = 4'd0; idx[1] = 4'd0;
      fork
         forever begin
            @(negedge clk);
            compare_cycle();
         end
      join_none
      repeat (3) tick();
      chk_zero(0, "reset");
      chk_zero(1, "reset");
      rst_n = 1'b1;
      repeat (2) tick();

      // Single image, idx 0.
      s = cyc + 1; en[0] = 1'b1;
      wait_fin(0, 60);
      chk("t1_fin_cyc", 0, 64'(fin_cyc[0]), 64'(s + 18));
      chk("t1_start", 0, 64'(run_start[0]), 64'(s));
      chk("t1_addr0", 0, 64'(run_addr0[0]), 64'd0);
      chk("t1_last_addr", 0, 64'(last_addr[0]), 64'd15);
      chk("t1_pixels", 0, 64'(pix_cnt[0]), 64'd16);
      chk("t1_windows", 0, 64'(wmask[0]), 64'h0000_0000_0000_CC00);
      chk("t1_first_pix", 0, 64'(first_pix[0]), 64'h0000_0000_A500_FF3C);
      tick(); en[0] = 1'b0;
      repeat (3) tick();

      // Manager model: two images back to back, then the enable drops.
      f0 = fin_total[0]; s = cyc + 1; idx[0] = 4'd0; en[0] = 1'b1;
      wait_fin(0, 60);
      chk("t2_fin1_cyc", 0, 64'(fin_cyc[0]), 64'(s + 18));
      tick(); idx[0] = 4'd1;
      wait_fin(0, 60);
      chk("t2_fin2_cyc", 0, 64'(fin_cyc[0]), 64'(s + 38));
      chk("t2_start2", 0, 64'(run_start[0]), 64'(s + 20));
      chk("t2_addr0", 0, 64'(run_addr0[0]), 64'd16);
      chk("t2_last_addr", 0, 64'(last_addr[0]), 64'd31);
      chk("t2_first_pix", 0, 64'(first_pix[0]), 64'h0000_0000_A510_EF3C);
      tick(); en[0] = 1'b0; idx[0] = 4'd0;
      repeat (10) tick();
      chk("t3_fin_count", 0, 64'(fin_total[0]), 64'(f0 + 2));
      chk("t3_idle_rd_en", 0, 64'(rd_w[0]), 64'd0);

      // Abort at READ cycle S+5, then restart.
      s = cyc + 1; en[0] = 1'b1;
      repeat (6) tick();
      en[0] = 1'b0;
      #1;
      chk("abort_rd_same_cycle", 0, 64'(rd_w[0]), 64'd0);
      f0 = fin_total[0];
      repeat (6) tick();
      chk("abort_no_fin", 0, 64'(fin_total[0]), 64'(f0));
      chk("abort_pv_low", 0, 64'(pv_w[0]), 64'd0);
      s = cyc + 1; en[0] = 1'b1;
      wait_fin(0, 60);
      chk("restart_start", 0, 64'(run_start[0]), 64'(s));
      chk("restart_addr0", 0, 64'(run_addr0[0]), 64'd0);
      chk("restart_pixels", 0, 64'(pix_cnt[0]), 64'd16);
      chk("restart_fin_cyc", 0, 64'(fin_cyc[0]), 64'(s + 18));
      tick(); en[0] = 1'b0;
      repeat (3) tick();

      // Asynchronous reset at S+8 mid-image.
      s = cyc + 1; en[0] = 1'b1;
      repeat (9) tick();
      #1 rst_n = 1'b0;
      #1;
      chk_zero(0, "mid_reset");
      tick(); rst_n = 1'b1;
      s = cyc + 1;
      wait_fin(0, 60);
      chk("post_rst_fin_cyc", 0, 64'(fin_cyc[0]), 64'(s + 18));
      chk("post_rst_addr0", 0, 64'(run_addr0[0]), 64'd0);
      chk("post_rst_pixels", 0, 64'(pix_cnt[0]), 64'd16);
      chk("post_rst_windows", 0, 64'(wmask[0]), 64'h0000_0000_0000_CC00);
      tick(); en[0] = 1'b0;
      repeat (3) tick();

      // 3x3 image with idx 2 on the second instance.
      s = cyc + 1; idx[1] = 4'd2; en[1] = 1'b1;
      wait_fin(1, 40);
      chk("n3_fin_cyc", 1, 64'(fin_cyc[1]), 64'(s + 11));
      chk("n3_start", 1, 64'(run_start[1]), 64'(s));
      chk("n3_addr0", 1, 64'(run_addr0[1]), 64'd18);
      chk("n3_last_addr", 1, 64'(last_addr[1]), 64'd26);
      chk("n3_pixels", 1, 64'(pix_cnt[1]), 64'd9);
      chk("n3_windows", 1, 64'(wmask[1]), 64'h0000_0000_0000_0100);
      chk("n3_first_pix", 1, 64'(first_pix[1]), 64'h0000_0000_A512_ED3C);
      tick(); en[1] = 1'b0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
